debounce_fsm: RTL and testbench

//  Cleans a raw mechanical switch/button input into a stable level for the edge detector stage.

---
 rtl/debounce_pkg.sv | 29 ++
 rtl/bit_sync.sv | 38 +++
 rtl/debounce_fsm.sv | 122 ++++++++++++
 tb/tb_debounce_fsm.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : debounce_pkg                                                    |
// | Purpose  : Shared types and helpers for the switch debouncer. The state    |
// |            encoding is also used by the testbench to observe the FSM.      |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package debounce_pkg;

   // ZERO/ONE are the stable levels; WAIT1/WAIT0 qualify a candidate change.
   typedef enum logic [1:0] {
      ZERO  = 2'd0,
      WAIT1 = 2'd1,
      ONE   = 2'd2,
      WAIT0 = 2'd3
   } db_state_t;

   // While qualifying a fall (WAIT0) the accepted level is still high.
   function automatic logic state_is_high(input db_state_t s);
      return (s == ONE) || (s == WAIT0);
   endfunction

   function automatic logic state_is_busy(input db_state_t s);
      return (s == WAIT1) || (s == WAIT0);
   endfunction

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/bit_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bit_sync                                                        |
// | Purpose  : Multi-flop synchronizer for one asynchronous bit. Flops reset   |
// |            to 0 so the debouncer starts from a known low input.            |
// | Macro    : DB_SYNC_EN - the module is only built when the debouncer's      |
// |            front-end synchronizer is enabled.                              |
// | Ports    : clk   in  1  sampling clock                                     |
// |            rst_n in  1  asynchronous active-low reset                      |
// |            d     in  1  asynchronous input                                 |
// |            q     out 1  synchronized output (STAGES cycles of latency)     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`ifdef DB_SYNC_EN
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], d};
      end
   end

   assign q = r_sync[STAGES-1];

endmodule : bit_sync
`endif
`default_nettype wire

// File: rtl/debounce_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : debounce_fsm                                                    |
// | Purpose  : Turns a bouncing switch input into a stable level for the edge  |
// |            detector. A change is accepted only after DB_CYCLES+1           |
// |            consecutive samples of the new value.                           |
// | Macro    : DB_SYNC_EN - when defined, sw passes through a SYNC_STAGES-flop |
// |            synchronizer first (needed for real pins). When undefined, sw   |
// |            must already be synchronous to clk.                             |
// | Ports    : clk      in  1  single clock, posedge                           |
// |            rst_n    in  1  asynchronous active-low reset                   |
// |            sw       in  1  raw switch input                                |
// |            db_level out 1  debounced level                                 |
// |            db_busy  out 1  high while a candidate change is qualified      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module debounce_fsm
   import debounce_pkg::*;
#(
   parameter int DB_CYCLES   = 500_000,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw,
   output logic db_level,
   output logic db_busy
);

   localparam int                 c_cnt_w    = $clog2(DB_CYCLES + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(DB_CYCLES - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

   // Parameter sanity: reject configurations the design cannot honour.
   generate
      if (DB_CYCLES < 1 || SYNC_STAGES < 2) begin : g_param_check
         $error("debounce_fsm: need DB_CYCLES >= 1 and SYNC_STAGES >= 2");
      end
   endgenerate

   logic w_sw_s;

`ifdef DB_SYNC_EN
   bit_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (sw),
      .q     (w_sw_s)
   );
`else
   assign w_sw_s = sw;
`endif

   db_state_t          r_state;
   db_state_t          w_state_nxt;
   logic [c_cnt_w-1:0] r_cnt;
   logic [c_cnt_w-1:0] w_cnt_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ZERO;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // The first differing sample enters WAITx with DB_CYCLES-1 loaded, so the
   // change lands after DB_CYCLES further equal samples. Any opposite sample
   // while waiting falls straight back to the stable state.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ZERO: begin
            if (w_sw_s) begin
               w_state_nxt = WAIT1;
               w_cnt_nxt   = c_cnt_load;
            end
         end
         WAIT1: begin
            if (!w_sw_s) begin
               w_state_nxt = ZERO;
            end else if (r_cnt == '0) begin
               w_state_nxt = ONE;
            end else begin
               w_cnt_nxt = r_cnt - c_cnt_one;
            end
         end
         ONE: begin
            if (!w_sw_s) begin
               w_state_nxt = WAIT0;
               w_cnt_nxt   = c_cnt_load;
            end
         end
         WAIT0: begin
            if (w_sw_s) begin
               w_state_nxt = ONE;
            end else if (r_cnt == '0) begin
               w_state_nxt = ZERO;
            end else begin
               w_cnt_nxt = r_cnt - c_cnt_one;
            end
         end
         default: begin
            w_state_nxt = ZERO;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Moore outputs straight from the state register: no combinational glitches.
   always_comb begin
      db_level = state_is_high(r_state);
      db_busy  = state_is_busy(r_state);
   end

endmodule : debounce_fsm
`default_nettype wire

// File: tb/tb_debounce_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_debounce_fsm                                                 |
// | Purpose  : Self-checking bench for debounce_fsm (DB_CYCLES=4,             |
// |            SYNC_STAGES=2). Works with or without DB_SYNC_EN; the input    |
// |            latency S follows the macro.                                    |
// | Ports    : none                                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_debounce_fsm;
   import debounce_pkg::*;

   localparam int DB = 4;
   localparam int SS = 2;
`ifdef DB_SYNC_EN
   localparam int S = SS;
`else
   localparam int S = 0;
`endif

   logic clk;
   logic rst_n;
   logic sw;
   logic db_level;
   logic db_busy;

   debounce_fsm #(
      .DB_CYCLES   (DB),
      .SYNC_STAGES (SS)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sw       (sw),
      .db_level (db_level),
      .db_busy  (db_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic      level;
      logic      busy;
      db_state_t state;
   } exp_t;

   exp_t q_exp[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: the length of the current run of samples that differ
   // from the accepted level. A run of DB+1 flips the level.
   logic m_lvl;
   int   m_run;
   logic m_pipe[$];

   task automatic model_reset();
      m_lvl = 1'b0;
      m_run = 0;
      m_pipe.delete();
      for (int i = 0; i < S; i++) m_pipe.push_back(1'b0);
   endtask

   // Drive one sample, predict, advance one edge, compare.
   task automatic step(input logic v, input string tag);
      logic x;
      exp_t e;
      exp_t got;
      @(negedge clk);
      sw = v;
      m_pipe.push_back(v);
      x = m_pipe.pop_front();
      if (x != m_lvl) begin
         m_run++;
         if (m_run == DB + 1) begin
            m_lvl = x;
            m_run = 0;
         end
      end else begin
         m_run = 0;
      end
      e.level = m_lvl;
      e.busy  = (m_run > 0);
      e.state = m_lvl ? ((m_run > 0) ? WAIT0 : ONE) : ((m_run > 0) ? WAIT1 : ZERO);
      q_exp.push_back(e);
      @(posedge clk);
      #1;
      got.level = db_level;
      got.busy  = db_busy;
      got.state = dut.r_state;
      e = q_exp.pop_front();
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL %s: got level=%0b busy=%0b state=%0d, want level=%0b busy=%0b state=%0d",
                  tag, got.level, got.busy, got.state, e.level, e.busy, e.state);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      sw    = 1'b0;
      #1;
      checks++;
      if (db_level !== 1'b0 || db_busy !== 1'b0 || dut.r_state !== ZERO) begin
         errors++;
         $display("FAIL reset_hold: got level=%0b busy=%0b state=%0d, want 0 0 0",
                  db_level, db_busy, dut.r_state);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 20; i++) step(1'b0, "reset_idle");
   endtask

   task automatic test_rise();
      int first_busy = -1;
      int first_lvl  = -1;
      for (int k = 0; k < 30; k++) begin
         step(1'b1, "rise");
         if (db_busy === 1'b1 && first_busy < 0) first_busy = k;
         if (db_level === 1'b1 && first_lvl < 0) first_lvl = k;
      end
      checks++;
      if (first_busy != S) begin
         errors++;
         $display("FAIL rise_busy_edge: got %0d want %0d", first_busy, S);
      end
      checks++;
      if (first_lvl != S + DB) begin
         errors++;
         $display("FAIL rise_level_edge: got %0d want %0d", first_lvl, S + DB);
      end
   endtask

   task automatic test_glitch_reject();
      logic saw_busy = 1'b0;
      logic dropped  = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step(1'b0, "glitch_low");
         if (db_busy === 1'b1) saw_busy = 1'b1;
         if (db_level !== 1'b1) dropped = 1'b1;
      end
      for (int k = 0; k < 10; k++) begin
         step(1'b1, "glitch_high");
         if (db_busy === 1'b1) saw_busy = 1'b1;
         if (db_level !== 1'b1) dropped = 1'b1;
      end
      checks++;
      if (saw_busy !== 1'b1 || dropped !== 1'b0 || dut.r_state !== ONE) begin
         errors++;
         $display("FAIL glitch_summary: got busy_seen=%0b dropped=%0b state=%0d, want 1 0 %0d",
                  saw_busy, dropped, dut.r_state, ONE);
      end
   endtask

   task automatic test_fall();
      int first_low = -1;
      for (int k = 0; k < 30; k++) begin
         step(1'b0, "fall");
         if (db_level === 1'b0 && first_low < 0) first_low = k;
      end
      checks++;
      if (first_low != S + DB) begin
         errors++;
         $display("FAIL fall_level_edge: got %0d want %0d", first_low, S + DB);
      end
   endtask

   task automatic test_bounce();
      logic [4:0] pat;
      int first_lvl = -1;
      pat = 5'b10101;
      for (int k = 0; k < 5; k++) begin
         step(pat[4-k], "bounce");
         if (db_level === 1'b1 && first_lvl < 0) first_lvl = k;
      end
      for (int k = 5; k < 30; k++) begin
         step(1'b1, "bounce_hold");
         if (db_level === 1'b1 && first_lvl < 0) first_lvl = k;
      end
      // Last rising sample is index 4.
      checks++;
      if (first_lvl != 4 + S + DB) begin
         errors++;
         $display("FAIL bounce_level_edge: got %0d want %0d", first_lvl, 4 + S + DB);
      end
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < S + 2; k++) step(1'b0, "pre_reset_wait0");
      checks++;
      if (dut.r_state !== WAIT0 || db_level !== 1'b1) begin
         errors++;
         $display("FAIL areset_setup: got state=%0d level=%0b want %0d 1",
                  dut.r_state, db_level, WAIT0);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (db_level !== 1'b0) begin
         errors++;
         $display("FAIL areset_level: got %0b want 0", db_level);
      end
      checks++;
      if (db_busy !== 1'b0 || dut.r_state !== ZERO) begin
         errors++;
         $display("FAIL areset_state: got busy=%0b state=%0d want 0 %0d",
                  db_busy, dut.r_state, ZERO);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int k = 0; k < 8; k++) step(1'b0, "post_reset");
   endtask

   task automatic test_random();
      int  len;
      logic v = 1'b0;
      for (int b = 0; b < 40; b++) begin
         v   = ~v;
         len = $urandom_range(1, 2 * DB + 3);
         for (int k = 0; k < len; k++) step(v, "random");
      end
      for (int k = 0; k < 2 * (S + DB + 1); k++) step(1'b0, "random_tail");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_rise();
      test_glitch_reject();
      test_fall();
      test_bounce();
      test_async_reset();
      test_random();
      checks++;
      if (q_exp.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d left want 0", q_exp.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_debounce_fsm
`default_nettype wire
